// File: rtl/mem_ctrl_pipe_if.sv
// rtl/mem_ctrl_pipe_if.sv - request/response bus between a bus master and mem_ctrl_pipe
interface mem_ctrl_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);
  logic                    valid_i;
  logic                    ready_o;
  logic                    wr_rd_en_i;
  logic [ADDR_WIDTH-1:0]   addr_i;
  logic [DATA_WIDTH-1:0]   wdata_i;
  logic [DATA_WIDTH/8-1:0] be_i;
  logic                    rvalid_o;
  logic                    rready_i;
  logic [DATA_WIDTH-1:0]   rdata_o;
  logic                    rerr_o;
  logic                    init_done_o;

  modport slave (
    input  valid_i, wr_rd_en_i, addr_i, wdata_i, be_i, rready_i,
    output ready_o, rvalid_o, rdata_o, rerr_o, init_done_o
  );

  modport master (
    output valid_i, wr_rd_en_i, addr_i, wdata_i, be_i, rready_i,
    input  ready_o, rvalid_o, rdata_o, rerr_o, init_done_o
  );
endinterface

// File: rtl/mem_ctrl_pipe.sv
// rtl/mem_ctrl_pipe.sv - single-port memory controller with byte-enable writes,
// pipelined reads, bounded in-order response buffer and post-reset clear sweep
module mem_ctrl_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RD_LATENCY = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mem_ctrl_pipe_if.slave bus
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_W-1:0]      RSP_FULL  = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(RSP_DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_init_ptr, w_init_ptr_nxt;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_ready, w_acc, w_wr_acc, w_rd_acc, w_oor, w_pop;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_push_v, w_push_err;
  logic [DATA_WIDTH-1:0] w_push_data;

  logic [DATA_WIDTH-1:0] r_fifo_data [RSP_DEPTH];
  logic [RSP_DEPTH-1:0]  r_fifo_err;
  logic [PTR_W-1:0]      r_wptr, r_rptr;
  logic [CNT_W-1:0]      r_fcnt, r_outst;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_INIT;
      r_init_ptr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_ptr <= w_init_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_ptr_nxt = r_init_ptr;
    if (r_state == S_INIT) begin
      w_init_ptr_nxt = r_init_ptr + ADDR_WIDTH'(1);
      if (r_init_ptr == LAST_ADDR) begin
        w_state_nxt    = S_RUN;
        w_init_ptr_nxt = '0;
      end
    end
  end

  // Outstanding covers pipeline plus buffer, so holding it below RSP_DEPTH keeps the buffer from overflowing.
  assign w_ready   = (r_state == S_RUN) && (r_outst < RSP_FULL);
  assign w_acc     = bus.valid_i && w_ready;
  assign w_wr_acc  = w_acc && bus.wr_rd_en_i;
  assign w_rd_acc  = w_acc && !bus.wr_rd_en_i;
  assign w_oor     = {1'b0, bus.addr_i} >= DEPTH_EXT;
  assign w_rd_data = w_oor ? '0 : r_mem[bus.addr_i];
  assign w_pop     = (r_fcnt != '0) && bus.rready_i;

  always_ff @(posedge clk_i) begin
    if (r_state == S_INIT) begin
      r_mem[r_init_ptr] <= '0;
    end else if (w_wr_acc && !w_oor) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.be_i[b]) r_mem[bus.addr_i][8*b +: 8] <= bus.wdata_i[8*b +: 8];
      end
    end
  end

  // The array read at accept is the first stage; RD_LATENCY-1 further stages precede the buffer.
  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign w_push_v    = w_rd_acc;
      assign w_push_err  = w_oor;
      assign w_push_data = w_rd_data;
    end else begin : g_pipe
      localparam int NS = RD_LATENCY - 1;
      logic [NS-1:0]         r_pv, r_pe;
      logic [DATA_WIDTH-1:0] r_pd [NS];

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          r_pv <= '0;
          r_pe <= '0;
          for (int i = 0; i < NS; i++) r_pd[i] <= '0;
        end else begin
          r_pv[0] <= w_rd_acc;
          r_pe[0] <= w_oor;
          r_pd[0] <= w_rd_data;
          for (int i = 1; i < NS; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pe[i] <= r_pe[i-1];
            r_pd[i] <= r_pd[i-1];
          end
        end
      end

      assign w_push_v    = r_pv[NS-1];
      assign w_push_err  = r_pe[NS-1];
      assign w_push_data = r_pd[NS-1];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (w_push_v) begin
      r_fifo_data[r_wptr] <= w_push_data;
      r_fifo_err[r_wptr]  <= w_push_err;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_fcnt  <= '0;
      r_outst <= '0;
    end else begin
      if (w_push_v) r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + PTR_W'(1);
      if (w_pop)    r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + PTR_W'(1);
      case ({w_push_v, w_pop})
        2'b10:   r_fcnt <= r_fcnt + CNT_W'(1);
        2'b01:   r_fcnt <= r_fcnt - CNT_W'(1);
        default: r_fcnt <= r_fcnt;
      endcase
      case ({w_rd_acc, w_pop})
        2'b10:   r_outst <= r_outst + CNT_W'(1);
        2'b01:   r_outst <= r_outst - CNT_W'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

  assign bus.ready_o     = w_ready;
  assign bus.rvalid_o    = (r_fcnt != '0);
  assign bus.rdata_o     = bus.rvalid_o ? r_fifo_data[r_rptr] : '0;
  assign bus.rerr_o      = bus.rvalid_o && r_fifo_err[r_rptr];
  assign bus.init_done_o = (r_state == S_RUN);
endmodule

// File: tb/tb_mem_ctrl_pipe.sv
// tb/tb_mem_ctrl_pipe.sv - scoreboard bench for mem_ctrl_pipe (DEPTH=48, RD_LATENCY=2, RSP_DEPTH=4)
module tb_mem_ctrl_pipe;
  localparam int DW    = 16;
  localparam int DEPTH = 48;
  localparam int AW    = $clog2(DEPTH);
  localparam int LAT   = 2;
  localparam int RSP   = 4;
  localparam int BW    = DW / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_ctrl_pipe #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD_LATENCY(LAT), .RSP_DEPTH(RSP)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_rsp   = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW:0]   exp_q [$];

  // Inputs change just after posedge, so at negedge both handshakes show what the next edge does.
  always @(negedge clk) begin : scoreboard
    logic [DW:0] e;
    if (rst_n) begin
      if (bus.rvalid_o && bus.rready_i) begin
        n_rsp++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: got rerr=%b rdata=%h, required no response", bus.rerr_o, bus.rdata_o);
        end else begin
          e = exp_q.pop_front();
          if ({bus.rerr_o, bus.rdata_o} !== e) begin
            n_fail++;
            $display("FAIL rsp_data: got rerr=%b rdata=%h, required rerr=%b rdata=%h",
                     bus.rerr_o, bus.rdata_o, e[DW], e[DW-1:0]);
          end
        end
      end
      if (bus.valid_i && bus.ready_o) begin
        if (bus.wr_rd_en_i) begin
          if (int'(bus.addr_i) < DEPTH)
            for (int b = 0; b < BW; b++)
              if (bus.be_i[b]) model[bus.addr_i][8*b +: 8] = bus.wdata_i[8*b +: 8];
        end else if (int'(bus.addr_i) >= DEPTH) begin
          exp_q.push_back({1'b1, {DW{1'b0}}});
        end else begin
          exp_q.push_back({1'b0, model[bus.addr_i]});
        end
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic issue(input bit wr, input int addr, input logic [DW-1:0] d, input logic [BW-1:0] be);
    int t = 0;
    bus.valid_i = 1'b1; bus.wr_rd_en_i = wr; bus.addr_i = AW'(addr); bus.wdata_i = d; bus.be_i = be;
    do begin @(negedge clk); t++; end while (!bus.ready_o && t < 200);
    if (!bus.ready_o) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: ready_o=%b, required 1 within 200 cycles", bus.ready_o);
    end
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_init(output int cycles);
    bit early_ready = 0;
    cycles = 0;
    do begin
      @(posedge clk); cycles++;
      @(negedge clk);
      if (!bus.init_done_o && bus.ready_o) early_ready = 1;
    end while (!bus.init_done_o && cycles < 500);
    n_tests++;
    if (early_ready) begin
      n_fail++; $display("FAIL init_ready: got ready_o=1 during init, required 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t = 0;
    bus.rready_i = 1'b1;
    while (exp_q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    repeat (LAT + 2) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL drain: got %0d responses pending, required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int cyc;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.ready_o, bus.rvalid_o, bus.rdata_o, bus.rerr_o, bus.init_done_o} !== {(DW+4){1'b0}}) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b rvalid=%b rdata=%h rerr=%b init_done=%b, required all 0",
               bus.ready_o, bus.rvalid_o, bus.rdata_o, bus.rerr_o, bus.init_done_o);
    end
    clear_model();
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init(cyc);
    n_tests++;
    if (cyc != DEPTH) begin
      n_fail++; $display("FAIL init_cycles: got %0d, required %0d", cyc, DEPTH);
    end
    n_tests++;
    if (bus.ready_o !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_init: got %b, required 1", bus.ready_o);
    end
    issue(0, DEPTH - 1, '0, '0);
    drain();
  endtask

  task automatic test_byte_enable();
    issue(1, 5, 16'hABCD, 2'b11);
    issue(1, 5, 16'h1200, 2'b10);
    bus.rready_i = 1'b1;
    issue(0, 5, '0, '0);
    @(negedge clk);
    n_tests++;
    if (bus.rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL latency_early: got rvalid=%b one cycle after accept, required 0", bus.rvalid_o);
    end
    @(negedge clk);
    n_tests++;
    if ({bus.rvalid_o, bus.rdata_o} !== {1'b1, 16'h12CD}) begin
      n_fail++;
      $display("FAIL latency_data: got rvalid=%b rdata=%h, required rvalid=1 rdata=12cd", bus.rvalid_o, bus.rdata_o);
    end
    @(posedge clk); #1;
    issue(1, 5, 16'hFFFF, 2'b00);
    issue(0, 5, '0, '0);
    issue(1, 5, 16'h0077, 2'b01);
    issue(0, 5, '0, '0);
    drain();
  endtask

  task automatic test_out_of_range();
    issue(1, 2, 16'h0000, 2'b11);
    issue(1, 50, 16'hBEEF, 2'b11);
    issue(0, 2, '0, '0);
    issue(0, 50, '0, '0);
    issue(1, DEPTH - 1, 16'h5A5A, 2'b11);
    issue(0, DEPTH - 1, '0, '0);
    drain();
    issue(0, DEPTH, '0, '0);
    repeat (LAT - 1) @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.rvalid_o, bus.rerr_o, bus.rdata_o} !== {2'b11, 16'h0000}) begin
      n_fail++;
      $display("FAIL oor_boundary: got rvalid=%b rerr=%b rdata=%h, required 1 1 0000",
               bus.rvalid_o, bus.rerr_o, bus.rdata_o);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic [DW-1:0] held;
    for (int i = 1; i <= 4; i++) issue(1, i, DW'(16'h1111 * i), 2'b11);
    bus.rready_i = 1'b0;
    bus.valid_i = 1'b1; bus.wr_rd_en_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.addr_i = AW'(1 + (i % 4));
      @(negedge clk);
      if (bus.ready_o) acc++;
      @(posedge clk); #1;
    end
    bus.valid_i = 1'b0;
    n_tests++;
    if (acc != RSP || bus.ready_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_accepts: got %0d accepted ready=%b, required %0d ready=0", acc, bus.ready_o, RSP);
    end
    held = bus.rdata_o;
    @(negedge clk);
    n_tests++;
    if ({bus.rvalid_o, bus.rdata_o} !== {1'b1, held}) begin
      n_fail++; $display("FAIL bp_hold: got rvalid=%b rdata=%h, required 1 %h", bus.rvalid_o, bus.rdata_o, held);
    end
    @(posedge clk); #1;
    bus.rready_i = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.ready_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready_pre: got %b before first consume, required 0", bus.ready_o);
    end
    @(negedge clk);
    n_tests++;
    if (bus.ready_o !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready_post: got %b after first consume, required 1", bus.ready_o);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int rsp0;
    bit rdy_ok = 1;
    bit rv_ok = 1;
    for (int i = 0; i < 8; i++) issue(1, i, DW'($urandom), 2'b11);
    bus.rready_i = 1'b1;
    rsp0 = n_rsp;
    bus.valid_i = 1'b1; bus.wr_rd_en_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.addr_i = AW'(i % 8);
      @(negedge clk);
      if (bus.ready_o) acc++; else rdy_ok = 0;
      if (i >= LAT && !bus.rvalid_o) rv_ok = 0;
      @(posedge clk); #1;
    end
    bus.valid_i = 1'b0;
    n_tests++;
    if (acc != 20 || !rdy_ok) begin
      n_fail++; $display("FAIL b2b_accepts: got %0d ready_ok=%b, required 20 ready_ok=1", acc, rdy_ok);
    end
    n_tests++;
    if (!rv_ok || (n_rsp - rsp0) != 20 - LAT) begin
      n_fail++; $display("FAIL b2b_returns: got %0d rvalid_ok=%b, required %0d rvalid_ok=1", n_rsp - rsp0, rv_ok, 20 - LAT);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int cyc;
    int rsp0;
    issue(1, 9, 16'hC0DE, 2'b11);
    bus.rready_i = 1'b0;
    issue(0, 9, '0, '0);
    issue(0, 1, '0, '0);
    issue(0, 2, '0, '0);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.rvalid_o, bus.ready_o, bus.init_done_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset: got rvalid=%b ready=%b init_done=%b, required 0 0 0",
               bus.rvalid_o, bus.ready_o, bus.init_done_o);
    end
    clear_model();
    rsp0 = n_rsp;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.rready_i = 1'b1;
    wait_init(cyc);
    n_tests++;
    if (cyc != DEPTH || n_rsp != rsp0) begin
      n_fail++; $display("FAIL reinit: got %0d cycles %0d stale, required %0d cycles 0 stale", cyc, n_rsp - rsp0, DEPTH);
    end
    issue(0, 9, '0, '0);
    issue(0, 5, '0, '0);
    drain();
  endtask

  initial begin
    bus.valid_i = 1'b0; bus.wr_rd_en_i = 1'b0; bus.addr_i = '0;
    bus.wdata_i = '0; bus.be_i = '0; bus.rready_i = 1'b0;
    test_reset();
    test_byte_enable();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
